// File: rtl/alu_wide.sv
`default_nettype none
// ============================================================================
// alu_wide : registered WIDTH-bit ALU with per-nibble BCD add/subtract and a
//            sequential unsigned shift-add multiplier (start/busy/done).
// Rev 1.0
// ============================================================================
module alu_wide #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RDY,
  input  logic [3:0]       op,
  input  logic             right,
  input  logic [WIDTH-1:0] AI,
  input  logic [WIDTH-1:0] BI,
  input  logic             CI,
  input  logic             BCD,
  input  logic             start,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] HI,
  output logic             CO,
  output logic             V,
  output logic             Z,
  output logic             N,
  output logic             HC,
  output logic             busy,
  output logic             done
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = $clog2(WIDTH);
  localparam logic [CW-1:0] c_LAST_STEP = CW'(WIDTH - 1);

  localparam logic [3:0] c_OP_ADD = 4'b0011;
  localparam logic [3:0] c_OP_SUB = 4'b0111;
  localparam logic [3:0] c_OP_DBL = 4'b1011;
  localparam logic [3:0] c_OP_OR  = 4'b1100;
  localparam logic [3:0] c_OP_AND = 4'b1101;
  localparam logic [3:0] c_OP_XOR = 4'b1110;

  logic [WIDTH-1:0]   out_q, hi_q, mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic               co_q, v_q, z_q, n_q, hc_q, busy_q, done_q;

  // Binary adder path; V is taken from here in both binary and BCD mode.
  logic             is_sub, is_arith;
  logic [WIDTH-1:0] bop, badd;
  logic [WIDTH:0]   bin_sum;
  logic             bin_v, bin_hc;

  assign is_sub   = (op == c_OP_SUB);
  assign is_arith = (op == c_OP_ADD) || (op == c_OP_SUB) || (op == c_OP_DBL);
  assign bop      = (op == c_OP_DBL) ? AI : BI;
  assign badd     = is_sub ? ~BI : bop;
  assign bin_sum  = {1'b0, AI} + {1'b0, badd} + {{WIDTH{1'b0}}, CI};
  assign bin_v    = (AI[WIDTH-1] == badd[WIDTH-1]) && (bin_sum[WIDTH-1] != AI[WIDTH-1]);
  assign bin_hc   = bin_sum[4] ^ AI[4] ^ badd[4];

  // Decimal chain: bcd_cy carries "carry" for add and "no borrow" for subtract.
  logic [NIB:0]     bcd_cy;
  logic [WIDTH-1:0] bcd_res;

  assign bcd_cy[0] = CI;

  for (genvar g = 0; g < NIB; g++) begin : g_bcd_nib
    logic [3:0] a, b;
    logic [4:0] s, d;
    assign a = AI[4*g +: 4];
    assign b = bop[4*g +: 4];
    assign s = {1'b0, a} + {1'b0, b} + {4'b0, bcd_cy[g]};
    assign d = {1'b0, a} - {1'b0, b} - {4'b0, ~bcd_cy[g]};
    assign bcd_res[4*g +: 4] = is_sub ? (d[4] ? d[3:0] - 4'd6 : d[3:0])
                                      : ((s > 5'd9) ? s[3:0] + 4'd6 : s[3:0]);
    assign bcd_cy[g+1] = is_sub ? ~d[4] : (s > 5'd9);
  end

  logic [WIDTH-1:0] res_d;
  logic             co_d, v_d, hc_d;

  always_comb begin
    res_d = AI;
    co_d  = 1'b0;
    v_d   = 1'b0;
    hc_d  = 1'b0;
    if (right) begin
      res_d = {CI, AI[WIDTH-1:1]};
      co_d  = AI[0];
    end else if (is_arith) begin
      v_d = bin_v;
      if (BCD) begin
        res_d = bcd_res;
        co_d  = bcd_cy[NIB];
        hc_d  = bcd_cy[1];
      end else begin
        res_d = bin_sum[WIDTH-1:0];
        co_d  = bin_sum[WIDTH];
        hc_d  = bin_hc;
      end
    end else begin
      case (op)
        c_OP_OR:  res_d = AI | BI;
        c_OP_AND: res_d = AI & BI;
        c_OP_XOR: res_d = AI ^ BI;
        default:  res_d = AI;
      endcase
    end
  end

  // Shift-add step: multiplier sits in the low half and is consumed LSB first.
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] acc_d;

  assign msum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_d = {msum, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= '0;
      hi_q    <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      hc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (RDY) begin
      done_q <= 1'b0;
      if (busy_q) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == c_LAST_STEP) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          out_q  <= acc_d[WIDTH-1:0];
          hi_q   <= acc_d[2*WIDTH-1:WIDTH];
          z_q    <= (acc_d == '0);
          n_q    <= acc_d[2*WIDTH-1];
          co_q   <= 1'b0;
          v_q    <= 1'b0;
          hc_q   <= 1'b0;
        end
      end else if (start) begin
        busy_q  <= 1'b1;
        cnt_q   <= '0;
        mcand_q <= AI;
        acc_q   <= {{WIDTH{1'b0}}, BI};
      end else begin
        out_q <= res_d;
        hi_q  <= '0;
        co_q  <= co_d;
        v_q   <= v_d;
        hc_q  <= hc_d;
        z_q   <= (res_d == '0);
        n_q   <= res_d[WIDTH-1];
      end
    end
  end

  assign OUT  = out_q;
  assign HI   = hi_q;
  assign CO   = co_q;
  assign V    = v_q;
  assign Z    = z_q;
  assign N    = n_q;
  assign HC   = hc_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_wide.sv
`default_nettype none
// ============================================================================
// tb_alu_wide : vector table, random ops vs. arithmetic model, multiply runs.
// Rev 1.0
// ============================================================================
module tb_alu_wide;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, rdy8, right8, ci8, bcd8, start8;
  logic [3:0] op8;
  logic [7:0] ai8, bi8, out8, hi8;
  logic       co8, v8, z8, n8, hc8, busy8, done8;

  logic        rst16, rdy16, right16, ci16, bcd16, start16;
  logic [3:0]  op16;
  logic [15:0] ai16, bi16, out16, hi16;
  logic        co16, v16, z16, n16, hc16, busy16, done16;

  alu_wide #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(rst8), .RDY(rdy8), .op(op8), .right(right8),
    .AI(ai8), .BI(bi8), .CI(ci8), .BCD(bcd8), .start(start8),
    .OUT(out8), .HI(hi8), .CO(co8), .V(v8), .Z(z8), .N(n8), .HC(hc8),
    .busy(busy8), .done(done8)
  );

  alu_wide #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset(rst16), .RDY(rdy16), .op(op16), .right(right16),
    .AI(ai16), .BI(bi16), .CI(ci16), .BCD(bcd16), .start(start16),
    .OUT(out16), .HI(hi16), .CO(co16), .V(v16), .Z(z16), .N(n16), .HC(hc16),
    .busy(busy16), .done(done16)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [7:0] out;
    logic co, v, z, n, hc;
  } res8_t;

  typedef struct {
    logic [3:0] op;
    logic       right, bcd;
    logic [7:0] ai, bi;
    logic       ci;
    logic [7:0] out;
    logic       co, v, z, n, hc;
  } vec_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // {HI,OUT,CO,V,Z,N,HC}
  task automatic chk_res8(input string nm, input logic [7:0] eo, input logic [7:0] eh,
                          input logic eco, input logic ev, input logic ez,
                          input logic en, input logic ehc);
    chk(nm, {hi8, out8, co8, v8, z8, n8, hc8}, {eh, eo, eco, ev, ez, en, ehc});
  endtask

  // Arithmetic reference, digit by digit with integers.
  function automatic res8_t model(input logic [3:0] op, input logic right, input logic bcd,
                                  input logic [7:0] ai, input logic [7:0] bi, input logic ci);
    res8_t r;
    int a, bv, beff, sum, sa, sb, ss, c, res, x, y, d;
    logic sub;
    r = '0;
    r.out = ai;
    a = int'(ai);
    if (right) begin
      r.out = {ci, ai[7:1]};
      r.co  = ai[0];
    end else if (op == 4'b0011 || op == 4'b0111 || op == 4'b1011) begin
      sub  = (op == 4'b0111);
      bv   = (op == 4'b1011) ? int'(ai) : int'(bi);
      beff = sub ? 255 - bv : bv;
      sa   = (a > 127) ? a - 256 : a;
      sb   = (beff > 127) ? beff - 256 : beff;
      ss   = sa + sb + int'(ci);
      r.v  = (ss > 127) || (ss < -128);
      if (!bcd) begin
        sum   = a + beff + int'(ci);
        r.out = 8'(sum);
        r.co  = (sum > 255);
        r.hc  = ((a % 16) + (beff % 16) + int'(ci)) > 15;
      end else begin
        c   = int'(ci);
        res = 0;
        for (int k = 0; k < 2; k++) begin
          x = (a >> (4 * k)) & 15;
          y = (bv >> (4 * k)) & 15;
          if (!sub) begin
            d = x + y + c;
            if (d > 9) begin d = d + 6; c = 1; end else c = 0;
          end else begin
            d = x - y - (1 - c);
            if (d < 0) begin d = (d - 6) & 15; c = 0; end else c = 1;
          end
          res = res | ((d & 15) << (4 * k));
          if (k == 0) r.hc = (c != 0);
        end
        r.out = 8'(res);
        r.co  = (c != 0);
      end
    end else begin
      case (op)
        4'b1100: r.out = ai | bi;
        4'b1101: r.out = ai & bi;
        4'b1110: r.out = ai ^ bi;
        default: r.out = ai;
      endcase
    end
    r.z = (r.out == 8'h00);
    r.n = r.out[7];
    return r;
  endfunction

  vec_t  vt[14];
  res8_t r;
  int    first_done, rdy_edges;
  logic  got;
  logic [7:0]  ma, mb;
  logic [15:0] prod;

  initial begin
    rst8 = 1'b1; rdy8 = 1'b1; op8 = 4'b1111; right8 = 1'b0; ai8 = '0; bi8 = '0;
    ci8 = 1'b0; bcd8 = 1'b0; start8 = 1'b0;
    rst16 = 1'b1; rdy16 = 1'b1; op16 = 4'b1111; right16 = 1'b0; ai16 = '0; bi16 = '0;
    ci16 = 1'b0; bcd16 = 1'b0; start16 = 1'b0;

    //                op       rt    bcd   ai     bi     ci    out    co    v     z     n     hc
    vt[0]  = '{4'b0011, 1'b0, 1'b1, 8'h45, 8'h38, 1'b0, 8'h83, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[1]  = '{4'b0111, 1'b0, 1'b1, 8'h10, 8'h01, 1'b1, 8'h09, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{4'b0111, 1'b0, 1'b1, 8'h00, 8'h01, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{4'b0111, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 8'h98, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{4'b0011, 1'b0, 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[5]  = '{4'b0011, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{4'b1100, 1'b0, 1'b0, 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{4'b1101, 1'b0, 1'b0, 8'hF0, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{4'b1110, 1'b0, 1'b0, 8'hAA, 8'hFF, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{4'b1111, 1'b0, 1'b1, 8'h3C, 8'hFF, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{4'b0000, 1'b0, 1'b0, 8'h81, 8'h7E, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[11] = '{4'b1011, 1'b0, 1'b0, 8'h80, 8'h00, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[12] = '{4'b0111, 1'b0, 1'b0, 8'h50, 8'h70, 1'b1, 8'hE0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[13] = '{4'b0011, 1'b0, 1'b1, 8'h99, 8'h99, 1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    tick; tick;
    chk_res8("reset8", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset8_hs", {busy8, done8}, 2'b00);
    chk("reset16", {hi16, out16, co16, v16, z16, n16, hc16, busy16, done16}, '0);
    rst8 = 1'b0; rst16 = 1'b0;

    // 16-bit decimal wrap and multiply aborted by reset
    op16 = 4'b0011; bcd16 = 1'b1; ai16 = 16'h9999; bi16 = 16'h0001; ci16 = 1'b0;
    tick;
    chk("bcd16_add", {hi16, out16, co16, v16, z16, n16, hc16},
        {16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    op16 = 4'b1111; bcd16 = 1'b0; ai16 = 16'h1234; bi16 = 16'h0002; start16 = 1'b1;
    tick;
    start16 = 1'b0;
    repeat (4) tick;
    chk("mul16_busy_pre_rst", busy16, 1'b1);
    rst16 = 1'b1;
    tick;
    rst16 = 1'b0;
    chk("mul16_rst", {hi16, out16, co16, v16, z16, n16, hc16, busy16, done16}, '0);
    start16 = 1'b1;
    tick;
    start16 = 1'b0;
    first_done = -1;
    for (int e = 1; e <= 40 && first_done < 0; e++) begin
      tick;
      if (done16) first_done = e;
    end
    chk("mul16_latency", first_done, 16);
    chk("mul16_result", {hi16, out16, z16, n16, co16}, {16'h0000, 16'h2468, 3'b000});

    // Table-driven single-cycle ops on the 8-bit core
    for (int i = 0; i < 14; i++) begin
      op8 = vt[i].op; right8 = vt[i].right; bcd8 = vt[i].bcd;
      ai8 = vt[i].ai; bi8 = vt[i].bi; ci8 = vt[i].ci;
      tick;
      chk_res8($sformatf("vec%0d", i), vt[i].out, 8'h00, vt[i].co, vt[i].v,
               vt[i].z, vt[i].n, vt[i].hc);
    end
    right8 = 1'b0; bcd8 = 1'b0;

    // 0xFF x 0xFF: busy exactly 8 edges, then a one-cycle done
    op8 = 4'b1111; ai8 = 8'hFF; bi8 = 8'hFF; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    chk("mulff_accept", {busy8, done8}, 2'b10);
    for (int e = 1; e <= 8; e++) begin
      tick;
      if (e < 8) chk($sformatf("mulff_busy%0d", e), {busy8, done8}, 2'b10);
    end
    chk("mulff_done", {busy8, done8}, 2'b01);
    chk_res8("mulff_result", 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    op8 = 4'b1111; ai8 = 8'h5A;
    tick;
    chk("mulff_done_clear", done8, 1'b0);
    chk_res8("pass_after_mul", 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stalled multiply with start held while busy
    ai8 = 8'h0F; bi8 = 8'h0E; start8 = 1'b1;
    tick;
    chk("stall_accept_hold", {busy8, out8}, {1'b1, 8'h5A});
    ai8 = 8'hFF; bi8 = 8'hFF;
    first_done = -1;
    for (int e = 1; e <= 30 && first_done < 0; e++) begin
      rdy8 = (e >= 3 && e <= 5) ? 1'b0 : 1'b1;
      tick;
      if (e == 4) chk("stall_hold_mid", {busy8, out8, hi8}, {1'b1, 8'h5A, 8'h00});
      if (done8) first_done = e;
    end
    start8 = 1'b0; rdy8 = 1'b1;
    chk("stall_latency", first_done, 11);
    chk_res8("stall_result", 8'hD2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // done holds through RDY=0, then back-to-back start on the done cycle
    rdy8 = 1'b0;
    tick;
    chk("done_hold_rdy0", {busy8, done8}, 2'b01);
    rdy8 = 1'b1; ai8 = 8'h12; bi8 = 8'h10; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    chk("b2b_accept", {busy8, done8}, 2'b10);
    first_done = -1;
    for (int e = 1; e <= 30 && first_done < 0; e++) begin
      tick;
      if (done8) first_done = e;
    end
    chk("b2b_latency", first_done, 8);
    chk_res8("b2b_result", 8'h20, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random single-cycle ops against the model
    for (int i = 0; i < 300; i++) begin
      case ($urandom % 3)
        0:       op8 = 4'b0011;
        1:       op8 = 4'b0111;
        default: op8 = 4'($urandom);
      endcase
      right8 = ($urandom % 8 == 0);
      bcd8   = 1'($urandom);
      ai8    = 8'($urandom);
      bi8    = 8'($urandom);
      ci8    = 1'($urandom);
      tick;
      r = model(op8, right8, bcd8, ai8, bi8, ci8);
      chk_res8($sformatf("rand%0d op=%b r=%b bcd=%b %h,%h,%b", i, op8, right8, bcd8, ai8, bi8, ci8),
               r.out, 8'h00, r.co, r.v, r.z, r.n, r.hc);
    end
    right8 = 1'b0; bcd8 = 1'b0;

    // Random multiplies with random RDY stalls
    for (int t = 0; t < 20; t++) begin
      ma = ($urandom % 5 == 0) ? 8'h00 : 8'($urandom);
      mb = 8'($urandom);
      prod = 16'(ma) * 16'(mb);
      rdy8 = 1'b1; ai8 = ma; bi8 = mb; start8 = 1'b1;
      tick;
      start8 = 1'b0;
      ai8 = 8'($urandom); bi8 = 8'($urandom);
      rdy_edges = 0;
      got = 1'b0;
      for (int e = 0; e < 100 && !got; e++) begin
        rdy8 = ($urandom % 4 != 0);
        tick;
        if (rdy8) rdy_edges++;
        if (done8) got = 1'b1;
      end
      rdy8 = 1'b1;
      chk($sformatf("rmul%0d_seen", t), got, 1'b1);
      chk($sformatf("rmul%0d_steps", t), rdy_edges, 8);
      chk_res8($sformatf("rmul%0d %h*%h", t, ma, mb), prod[7:0], prod[15:8],
               1'b0, 1'b0, (prod == 16'h0000), prod[15], 1'b0);
    end

    // RDY=0 freezes a single-cycle op; reset wins even with RDY low
    op8 = 4'b1111; ai8 = 8'hA5;
    tick;
    chk_res8("pass_a5", 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rdy8 = 1'b0; ai8 = 8'h11;
    tick;
    chk_res8("rdy0_hold", 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst8 = 1'b1;
    tick;
    rst8 = 1'b0; rdy8 = 1'b1;
    chk_res8("reset_rdy0", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
